// File: rtl/mul_arb_if.sv
// mul_arb_if: requester handshakes, response ports and shared multiplier port of mul_arb.
interface mul_arb_if;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_cmd, r0_a, r0_b, r1_cmd, r1_a, r1_b;
  logic        r0_rsp_valid, r0_rsp_ready, r1_rsp_valid, r1_rsp_ready;
  logic [63:0] r0_rsp_data, r1_rsp_data;
  logic        mul_en;
  logic [31:0] mul_command, mul_in_1, mul_in_2;
  logic [63:0] mul_out;
  logic        busy;

  modport slave (
    input  r0_valid, r0_cmd, r0_a, r0_b, r1_valid, r1_cmd, r1_a, r1_b,
           r0_rsp_ready, r1_rsp_ready, mul_out,
    output r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_data, r1_rsp_data,
           mul_en, mul_command, mul_in_1, mul_in_2, busy
  );

  modport master (
    output r0_valid, r0_cmd, r0_a, r0_b, r1_valid, r1_cmd, r1_a, r1_b,
           r0_rsp_ready, r1_rsp_ready, mul_out,
    input  r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_data, r1_rsp_data,
           mul_en, mul_command, mul_in_1, mul_in_2, busy
  );
endinterface

// File: rtl/mul_arb.sv
// mul_arb: two-requester arbiter sharing one MUL_LAT-cycle multiplier, with per-requester response FIFOs.
// Define MUL_ARB_PRIO_EN for fixed priority (requester 0 wins ties); otherwise round-robin.

module mul_arb_lane #(
  parameter int RSP_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_issue,
  input  logic        i_wr,
  input  logic [63:0] i_wdata,
  input  logic        i_rsp_ready,
  output logic        o_credit,
  output logic        o_rsp_valid,
  output logic [63:0] o_rsp_data
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0]                r_credit, r_cnt;
  logic [RSP_DEPTH-1:0][63:0]   r_mem;
  logic                         r_valid;
  logic                         w_pop;
  logic [CW-1:0]                w_wpos, w_cnt_nxt;

  assign w_pop     = r_valid & i_rsp_ready;
  assign w_wpos    = w_pop ? r_cnt - CW'(1) : r_cnt;
  assign w_cnt_nxt = r_cnt + CW'(i_wr) - CW'(w_pop);

  // Shift FIFO: entry 0 is the head and doubles as the registered output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credit <= CW'(RSP_DEPTH);
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_mem    <= '0;
    end else begin
      if (i_issue && !w_pop)      r_credit <= r_credit - CW'(1);
      else if (!i_issue && w_pop) r_credit <= r_credit + CW'(1);
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != '0);
      if (w_pop)
        for (int i = 0; i < RSP_DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      for (int i = 0; i < RSP_DEPTH; i++)
        if (i_wr && (w_wpos == CW'(i))) r_mem[i] <= i_wdata;
    end
  end

  assign o_credit    = (r_credit != '0);
  assign o_rsp_valid = r_valid;
  assign o_rsp_data  = r_mem[0];

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_wr && !w_pop && (r_cnt == CW'(RSP_DEPTH))));
endmodule

module mul_arb #(
  parameter int MUL_LAT   = 2,
  parameter int RSP_DEPTH = 2
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  mul_arb_if.slave  io_arb
);
  logic [1:0]        w_valid, w_credit, w_elig, w_grant, w_wr, w_rsp_ready, w_rsp_valid;
  logic [1:0][31:0]  w_cmd, w_a, w_b;
  logic [1:0][63:0]  w_rsp_data;
  logic [MUL_LAT-1:0] r_vld_pipe, r_id_pipe;

  assign w_valid     = {io_arb.r1_valid, io_arb.r0_valid};
  assign w_cmd       = {io_arb.r1_cmd, io_arb.r0_cmd};
  assign w_a         = {io_arb.r1_a, io_arb.r0_a};
  assign w_b         = {io_arb.r1_b, io_arb.r0_b};
  assign w_rsp_ready = {io_arb.r1_rsp_ready, io_arb.r0_rsp_ready};

  // Grants are forced low while reset is held so nothing leaks to the multiplier.
  assign w_elig = w_valid & w_credit & {2{i_rst_n}};

`ifdef MUL_ARB_PRIO_EN
  assign w_grant = w_elig[0] ? 2'b01 : w_elig;
`else
  logic r_last;

  always_comb begin
    w_grant = w_elig;
    if (&w_elig) w_grant = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_last <= 1'b1;
    else if (|w_grant) r_last <= w_grant[1];
  end
`endif

  assign io_arb.r0_ready    = w_grant[0];
  assign io_arb.r1_ready    = w_grant[1];
  assign io_arb.mul_en      = |w_grant;
  assign io_arb.mul_command = w_grant[0] ? w_cmd[0] : (w_grant[1] ? w_cmd[1] : '0);
  assign io_arb.mul_in_1    = w_grant[0] ? w_a[0]   : (w_grant[1] ? w_a[1]   : '0);
  assign io_arb.mul_in_2    = w_grant[0] ? w_b[0]   : (w_grant[1] ? w_b[1]   : '0);

  // Tag stage MUL_LAT-1 lines up with the cycle mul_out carries that product.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe[0] <= |w_grant;
      r_id_pipe[0]  <= w_grant[1];
      for (int i = 1; i < MUL_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_id_pipe[i]  <= r_id_pipe[i-1];
      end
    end
  end

  assign w_wr[0] = r_vld_pipe[MUL_LAT-1] & ~r_id_pipe[MUL_LAT-1];
  assign w_wr[1] = r_vld_pipe[MUL_LAT-1] &  r_id_pipe[MUL_LAT-1];

  for (genvar n = 0; n < 2; n++) begin : g_lane
    mul_arb_lane #(.RSP_DEPTH(RSP_DEPTH)) u_lane (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_issue     (w_grant[n]),
      .i_wr        (w_wr[n]),
      .i_wdata     (io_arb.mul_out),
      .i_rsp_ready (w_rsp_ready[n]),
      .o_credit    (w_credit[n]),
      .o_rsp_valid (w_rsp_valid[n]),
      .o_rsp_data  (w_rsp_data[n])
    );
  end

  assign io_arb.r0_rsp_valid = w_rsp_valid[0];
  assign io_arb.r1_rsp_valid = w_rsp_valid[1];
  assign io_arb.r0_rsp_data  = w_rsp_data[0];
  assign io_arb.r1_rsp_data  = w_rsp_data[1];
  assign io_arb.busy         = (|r_vld_pipe) | (|w_rsp_valid);
endmodule
